pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch sequencer: picks next_pc each cycle and runs the imem req/ack handshake.
// Latency: instruction presented to decode the cycle after imem_ack; next_pc is combinational.
// Backpressure: decode stall holds the instruction in HOLD; missing acks time out to EXC_VECTOR.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int          MAX_WAIT     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exception,
    output logic        fetch_error
);

    localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          timeout;
    logic          ack_in_req;

    // The fetch address is always the live PC register value.
    assign imem_addr  = pc_in;

    // A timeout is an ack-less REQ cycle once the counter has reached its last value.
    assign timeout    = (state == REQ) && (wait_cnt == LAST_WAIT) && !imem_ack;
    assign ack_in_req = (state == REQ) && imem_ack;

    // Next-PC selection: exception > timeout > redirect > per-state rule; PC is held by echoing pc_in.
    always_comb begin
        next_pc = pc_in;
        if (reset) begin
            next_pc = RESET_VECTOR;
        end else if (exception || timeout) begin
            next_pc = EXC_VECTOR;
        end else if (redirect_valid) begin
            next_pc = redirect_target & ~32'h3;
        end else if (ack_in_req) begin
            next_pc = pc_in + 32'd4;
        end
    end

    // Control FSM with registered handshake outputs and instruction capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fetch_error <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            fetch_error <= 1'b0;
            if (exception || redirect_valid) begin
                // Flush: any same-cycle ack is dropped and a fresh fetch starts at the target.
                state       <= REQ;
                imem_req    <= 1'b1;
                instr_valid <= 1'b0;
                wait_cnt    <= '0;
                // A timeout still outranks a redirect for the error pulse.
                if (!exception && timeout) begin
                    fetch_error <= 1'b1;
                end
            end else if (timeout) begin
                // Stay in REQ; the PC is already steered to the exception vector.
                fetch_error <= 1'b1;
                wait_cnt    <= '0;
            end else begin
                case (state)
                    BOOT: begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                    REQ: begin
                        if (imem_ack) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc_in;
                            state       <= HOLD;
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b1;
                            wait_cnt    <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            state       <= REQ;
                            imem_req    <= 1'b1;
                            instr_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= BOOT;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
